// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the fetch port, the load/store data port and the single-ported
//   memory bus that mem_arbiter sits between.
//
//   slave  : the arbiter's view. It receives requests and memory responses,
//            and drives completions and the memory access.
//   master : the environment's view. This is the fetch unit, the LSU and the
//            memory, modelled as one side.
//
//   Fetch  : if_req, if_addr -> if_rdata, if_valid
//   Data   : d_req, d_rw, d_store_sel, d_addr, d_wdata -> d_rdata, d_valid, d_err
//   Memory : mem_en, mem_we, mem_be, mem_addr, mem_wdata <- mem_rdata, mem_ready
//   Status : busy
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;

  logic        d_req;
  logic        d_rw;
  logic [1:0]  d_store_sel;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_err;

  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_rw, d_store_sel, d_addr, d_wdata,
           mem_rdata, mem_ready,
    output if_rdata, if_valid, d_rdata, d_valid, d_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_rw, d_store_sel, d_addr, d_wdata,
           mem_rdata, mem_ready,
    input  if_rdata, if_valid, d_rdata, d_valid, d_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported memory between instruction fetch and load/store.
//   Data requests win arbitration. Fetch is guaranteed a grant after
//   STARVE_MAX consecutive data grants made while it was waiting. The arbiter
//   runs one access at a time over a mem_en/mem_ready handshake, builds byte
//   enables and lane-replicated store data, and rejects misaligned data
//   accesses without touching memory.
//
//   Ports:
//     clock    rising-edge system clock
//     reset_n  asynchronous active-low reset; abandons any access in flight
//     bus      mem_arbiter_if.slave (fetch, data and memory sides plus busy)
//
//   Encodings:
//     d_rw         0 = read, 1 = write
//     d_store_sel  00 = byte, 01 = half, 10 = word
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);

  localparam logic       MEM_READ  = 1'b0;
  localparam logic       MEM_WRITE = 1'b1;
  localparam logic [1:0] STORE_B   = 2'b00;
  localparam logic [1:0] STORE_H   = 2'b01;
  localparam logic [1:0] STORE_W   = 2'b10;

  localparam int            CW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, IF_WAIT, D_WAIT, DONE} state_t;
  typedef enum logic       {PORT_IF, PORT_D}              port_t;

  state_t        state, next_state;
  port_t         port;       // port granted for the access in flight
  logic          err_q;      // granted data access was misaligned
  logic [CW-1:0] dcount;     // data grants in a row while fetch was waiting

  logic          grant_d, grant_if, d_misaligned;
  logic [1:0]    lane;
  logic [3:0]    d_be;
  logic [31:0]   d_wdata_rep;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign lane = bus.d_addr[1:0];

  assign d_misaligned = ((bus.d_store_sel == STORE_W) && (lane != 2'b00)) ||
                        ((bus.d_store_sel == STORE_H) && lane[0]);

  // Data has priority until fetch has been passed over STARVE_MAX times.
  assign grant_d  = bus.d_req && (!bus.if_req || (dcount != DMAX));
  assign grant_if = bus.if_req && !grant_d;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    d_be        = 4'b1111;
    d_wdata_rep = bus.d_wdata;
    unique case (bus.d_store_sel)
      STORE_H: begin
        d_be        = 4'b0011 << {lane[1], 1'b0};
        d_wdata_rep = {2{bus.d_wdata[15:0]}};
      end
      STORE_B: begin
        d_be        = 4'b0001 << lane;
        d_wdata_rep = {4{bus.d_wdata[7:0]}};
      end
      default: ;
    endcase
    if (bus.d_rw == MEM_READ) d_be = 4'b1111;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples pre-edge values no matter how the always blocks are ordered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (grant_d)       next_state = d_misaligned ? DONE : D_WAIT;
        else if (grant_if) next_state = IF_WAIT;
      end
      IF_WAIT, D_WAIT: if (bus.mem_ready) next_state = DONE;
      DONE:            next_state = IDLE;
      default:         next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.busy     = (state != IDLE);
    bus.if_valid = (state == DONE) && (port == PORT_IF);
    bus.d_valid  = (state == DONE) && (port == PORT_D);
    bus.d_err    = (state == DONE) && (port == PORT_D) && err_q;
  end

  // ---------------------------------------------------------------------------
  // Grant bookkeeping and registered memory interface
  // ---------------------------------------------------------------------------
  // NOTE: the read-data holding registers are reset along with the control
  // state. They are plain flops rather than a RAM, so the reset is cheap, and
  // both completion ports read 0 until their first access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      port          <= PORT_IF;
      err_q         <= 1'b0;
      dcount        <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'b0000;
      bus.mem_addr  <= 32'h0;
      bus.mem_wdata <= 32'h0;
      bus.if_rdata  <= 32'h0;
      bus.d_rdata   <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            port  <= PORT_D;
            err_q <= d_misaligned;
            // Count only grants that made a waiting fetch wait longer.
            if (bus.if_req) dcount <= (dcount == DMAX) ? DMAX : dcount + 1'b1;
            else            dcount <= '0;
            if (!d_misaligned) begin
              bus.mem_en    <= 1'b1;
              bus.mem_we    <= (bus.d_rw == MEM_WRITE);
              bus.mem_be    <= d_be;
              bus.mem_addr  <= bus.d_addr & 32'hFFFF_FFFC;
              bus.mem_wdata <= (bus.d_rw == MEM_WRITE) ? d_wdata_rep : 32'h0;
            end
          end else if (grant_if) begin
            port          <= PORT_IF;
            err_q         <= 1'b0;
            dcount        <= '0;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'b1111;
            bus.mem_addr  <= bus.if_addr & 32'hFFFF_FFFC;
            bus.mem_wdata <= 32'h0;
          end
        end
        IF_WAIT: begin
          if (bus.mem_ready) begin
            bus.mem_en   <= 1'b0;
            bus.if_rdata <= bus.mem_rdata;
          end
        end
        D_WAIT: begin
          if (bus.mem_ready) begin
            bus.mem_en <= 1'b0;
            // A store leaves the last loaded word in place.
            if (!bus.mem_we) bus.d_rdata <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed scenarios with literal expectations, followed by randomized
//   fetch/load/store traffic with random memory latency. A transaction-level
//   reference model runs on every falling edge and compares all DUT outputs
//   against it.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int unsigned STARVE_MAX = 4;
  localparam logic        MEM_READ   = 1'b0;
  localparam logic        MEM_WRITE  = 1'b1;
  localparam logic [1:0]  STORE_B    = 2'b00;
  localparam logic [1:0]  STORE_H    = 2'b01;
  localparam logic [1:0]  STORE_W    = 2'b10;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model. It tracks one transaction at a time: nothing in flight,
  // waiting on memory, or reporting completion.
  // -------------------------------------------------------------------------
  typedef enum {M_IDLE, M_MEM, M_DONE} mphase_t;

  mphase_t     m_phase  = M_IDLE;
  int          m_streak = 0;       // data grants in a row with fetch waiting
  bit          m_data, m_write, m_err;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_if_rdata = 32'h0;
  logic [31:0] m_d_rdata  = 32'h0;

  always @(negedge clock) begin
    if (!reset_n) begin
      check("rst busy",     bus.busy,     1'b0);
      check("rst mem_en",   bus.mem_en,   1'b0);
      check("rst mem_we",   bus.mem_we,   1'b0);
      check("rst mem_be",   bus.mem_be,   4'h0);
      check("rst mem_addr", bus.mem_addr, 32'h0);
      check("rst if_valid", bus.if_valid, 1'b0);
      check("rst d_valid",  bus.d_valid,  1'b0);
      check("rst d_err",    bus.d_err,    1'b0);
      check("rst if_rdata", bus.if_rdata, 32'h0);
      check("rst d_rdata",  bus.d_rdata,  32'h0);
      m_phase    = M_IDLE;
      m_streak   = 0;
      m_if_rdata = 32'h0;
      m_d_rdata  = 32'h0;
    end else begin
      // Compare this cycle.
      check("busy",     bus.busy,     m_phase != M_IDLE);
      check("mem_en",   bus.mem_en,   m_phase == M_MEM);
      if (m_phase == M_MEM) begin
        check("mem_we",   bus.mem_we,   m_write);
        check("mem_addr", bus.mem_addr, m_addr);
        check("mem_be",   bus.mem_be,   m_be);
        if (m_write) check("mem_wdata", bus.mem_wdata, m_wdata);
      end
      check("if_valid", bus.if_valid, (m_phase == M_DONE) && !m_data);
      check("d_valid",  bus.d_valid,  (m_phase == M_DONE) && m_data);
      check("d_err",    bus.d_err,    (m_phase == M_DONE) && m_data && m_err);
      check("if_rdata", bus.if_rdata, m_if_rdata);
      check("d_rdata",  bus.d_rdata,  m_d_rdata);

      // Advance to what the next cycle must look like.
      case (m_phase)
        M_IDLE: begin
          if (bus.d_req && (!bus.if_req || m_streak < STARVE_MAX)) begin
            int a;
            a        = int'(bus.d_addr[1:0]);
            m_streak = bus.if_req ? ((m_streak < STARVE_MAX) ? m_streak + 1 : m_streak) : 0;
            m_data   = 1'b1;
            m_write  = (bus.d_rw == MEM_WRITE);
            m_err    = ((bus.d_store_sel == STORE_W) && (a != 0)) ||
                       ((bus.d_store_sel == STORE_H) && (a % 2 == 1));
            m_addr   = bus.d_addr - 32'(a);
            if (!m_write || bus.d_store_sel == STORE_W) begin
              m_be    = 4'hF;
              m_wdata = bus.d_wdata;
            end else if (bus.d_store_sel == STORE_H) begin
              m_be    = 4'(3 << (a - a % 2));
              m_wdata = {16'h0, bus.d_wdata[15:0]} * 32'h0001_0001;
            end else begin
              m_be    = 4'(1 << a);
              m_wdata = {24'h0, bus.d_wdata[7:0]} * 32'h0101_0101;
            end
            m_phase = m_err ? M_DONE : M_MEM;
          end else if (bus.if_req) begin
            m_streak = 0;
            m_data   = 1'b0;
            m_write  = 1'b0;
            m_err    = 1'b0;
            m_addr   = bus.if_addr - 32'(bus.if_addr[1:0]);
            m_be     = 4'hF;
            m_phase  = M_MEM;
          end
        end
        M_MEM: begin
          if (bus.mem_ready) begin
            if (!m_data)       m_if_rdata = bus.mem_rdata;
            else if (!m_write) m_d_rdata  = bus.mem_rdata;
            m_phase = M_DONE;
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus: inputs change 1 time unit after the rising edge.
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.if_req      = 1'b0;
    bus.if_addr     = 32'h0;
    bus.d_req       = 1'b0;
    bus.d_rw        = MEM_READ;
    bus.d_store_sel = STORE_W;
    bus.d_addr      = 32'h0;
    bus.d_wdata     = 32'h0;
    bus.mem_rdata   = 32'h0;
    bus.mem_ready   = 1'b0;
  endtask

  task automatic new_fetch();
    bus.if_addr = $urandom;
    bus.if_req  = 1'b1;
  endtask

  task automatic new_data();
    bus.d_rw        = 1'($urandom_range(0, 1));
    bus.d_store_sel = 2'($urandom_range(0, 2));
    bus.d_addr      = $urandom;
    bus.d_wdata     = $urandom;
    bus.d_req       = 1'b1;
  endtask

  logic [9:0] order;
  int         grants;
  bit         saw_if, saw_d;

  initial begin
    quiet_inputs();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // 1: fetch with zero-wait memory.
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h00A0_0093;
    bus.if_addr   = 32'h104;
    bus.if_req    = 1'b1;
    tick();
    check("t1 mem_en",   bus.mem_en,   1'b1);
    check("t1 mem_addr", bus.mem_addr, 32'h104);
    check("t1 mem_be",   bus.mem_be,   4'b1111);
    check("t1 mem_we",   bus.mem_we,   1'b0);
    tick();
    check("t1 if_valid", bus.if_valid, 1'b1);
    check("t1 if_rdata", bus.if_rdata, 32'h00A0_0093);
    bus.if_req = 1'b0;
    tick();
    check("t1 idle", bus.busy, 1'b0);

    // 2: store byte to lane 3.
    bus.d_rw        = MEM_WRITE;
    bus.d_store_sel = STORE_B;
    bus.d_addr      = 32'h203;
    bus.d_wdata     = 32'h1234_56AB;
    bus.d_req       = 1'b1;
    tick();
    check("t2 mem_en",    bus.mem_en,    1'b1);
    check("t2 mem_addr",  bus.mem_addr,  32'h200);
    check("t2 mem_be",    bus.mem_be,    4'b1000);
    check("t2 mem_wdata", bus.mem_wdata, 32'hABAB_ABAB);
    check("t2 mem_we",    bus.mem_we,    1'b1);
    tick();
    check("t2 d_valid", bus.d_valid, 1'b1);
    check("t2 d_err",   bus.d_err,   1'b0);
    bus.d_req = 1'b0;
    tick();

    // 3: misaligned half store never reaches memory.
    bus.d_store_sel = STORE_H;
    bus.d_addr      = 32'h201;
    bus.d_req       = 1'b1;
    tick();
    check("t3 mem_en",  bus.mem_en,  1'b0);
    check("t3 d_valid", bus.d_valid, 1'b1);
    check("t3 d_err",   bus.d_err,   1'b1);
    bus.d_req = 1'b0;
    tick();
    check("t3 mem_en after", bus.mem_en, 1'b0);

    // 4: both ports held high -> D,D,D,D,F,D,D,D,D,F.
    bus.if_addr     = 32'h1000;
    bus.d_rw        = MEM_READ;
    bus.d_store_sel = STORE_W;
    bus.d_addr      = 32'h2000;
    bus.if_req      = 1'b1;
    bus.d_req       = 1'b1;
    order  = '0;
    grants = 0;
    for (int c = 0; c < 80 && grants < 10; c++) begin
      tick();
      if (bus.if_valid) begin order = {order[8:0], 1'b0}; grants++; end
      if (bus.d_valid)  begin order = {order[8:0], 1'b1}; grants++; end
    end
    check("t4 grant count", 32'(grants), 32'd10);
    check("t4 grant order", order, 10'b11110_11110);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();

    // 5: store word with memory stalling for 5 cycles.
    bus.mem_ready   = 1'b0;
    bus.d_rw        = MEM_WRITE;
    bus.d_store_sel = STORE_W;
    bus.d_addr      = 32'h10;
    bus.d_wdata     = 32'hCAFE_F00D;
    bus.d_req       = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t5 mem_en",    bus.mem_en,    1'b1);
      check("t5 mem_addr",  bus.mem_addr,  32'h10);
      check("t5 mem_be",    bus.mem_be,    4'b1111);
      check("t5 mem_wdata", bus.mem_wdata, 32'hCAFE_F00D);
      check("t5 d_valid",   bus.d_valid,   1'b0);
      tick();
    end
    bus.mem_ready = 1'b1;
    check("t5 mem_en ready", bus.mem_en, 1'b1);
    tick();
    check("t5 d_valid done", bus.d_valid, 1'b1);
    check("t5 d_err",        bus.d_err,   1'b0);
    bus.d_req     = 1'b0;
    bus.mem_ready = 1'b0;
    tick();

    // 7: fetch requester withdraws mid-access; completion still reported.
    bus.mem_rdata = 32'h5555_AAAA;
    bus.if_addr   = 32'h88;
    bus.if_req    = 1'b1;
    tick();
    bus.if_req = 1'b0;
    tick();
    bus.mem_ready = 1'b1;
    tick();
    check("t7 if_valid", bus.if_valid, 1'b1);
    check("t7 if_rdata", bus.if_rdata, 32'h5555_AAAA);
    bus.mem_ready = 1'b0;
    tick();

    // 6: reset during a data access.
    bus.d_rw        = MEM_READ;
    bus.d_store_sel = STORE_W;
    bus.d_addr      = 32'h40;
    bus.d_req       = 1'b1;
    tick();
    check("t6 mem_en before", bus.mem_en, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t6 mem_en async", bus.mem_en, 1'b0);
    check("t6 busy async",   bus.busy,   1'b0);
    bus.d_req = 1'b0;
    repeat (3) begin
      tick();
      check("t6 no d_valid", bus.d_valid, 1'b0);
    end
    reset_n       = 1'b1;
    bus.if_addr   = 32'h300;
    bus.mem_rdata = 32'h13;
    bus.mem_ready = 1'b1;
    bus.if_req    = 1'b1;
    tick();
    tick();
    check("t6 if_valid", bus.if_valid, 1'b1);
    check("t6 if_rdata", bus.if_rdata, 32'h13);
    bus.if_req = 1'b0;
    tick();

    // Random traffic; the model checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      saw_if = bus.if_valid;
      saw_d  = bus.d_valid;
      @(posedge clock);
      #1;
      if (saw_if) begin
        if ($urandom_range(0, 1) == 1) new_fetch();
        else                           bus.if_req = 1'b0;
      end else if (!bus.if_req && $urandom_range(0, 3) == 0) begin
        new_fetch();
      end
      if (saw_d) begin
        if ($urandom_range(0, 1) == 1) new_data();
        else                           bus.d_req = 1'b0;
      end else if (!bus.d_req && $urandom_range(0, 2) == 0) begin
        new_data();
      end
      bus.mem_ready = ($urandom_range(0, 9) < 4);
      bus.mem_rdata = $urandom;
    end

    bus.if_req    = 1'b0;
    bus.d_req     = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
